// File: rtl/data_sram_responder_if.sv
// ---------------------------------------------------------------------------
// data_sram_responder_if
//   Data SRAM request/response bundle between the pipeline's load/store path
//   (master: EXE issues requests, MEM consumes responses) and the memory-side
//   responder (slave).
// Signals
//   req      request valid
//   wr       1 = store, 0 = load
//   size     access size 0 byte / 1 half / 2 word (informational)
//   wstrb    store byte enables, lane i = wdata[8i+7:8i]
//   addr     byte address
//   wdata    store data
//   addr_ok  request accepted this cycle when req & addr_ok
//   data_ok  one-cycle response pulse, in request order
//   rdata    load data, valid while data_ok
// ---------------------------------------------------------------------------
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//   Memory-side responder for the data SRAM interface. Holds a word-addressed
//   RAM, accepts requests in order, commits stores at acceptance, captures load
//   data at acceptance, and returns one data_ok per request LATENCY cycles
//   after the accepting edge. Used as bench memory model and on-chip data store.
// Parameters
//   ADDR_W        word-index bits; RAM holds 2**ADDR_W 32-bit words
//   LATENCY       accept edge to data_ok high, in cycles (>= 1)
//   FIFO_DEPTH    max outstanding requests (power of 2, >= 2)
//   STALL_PERIOD  addr_ok stall period when the stall option is built (>= 2)
// Ports
//   clk     clock
//   resetn  synchronous active-low reset
//   bus     data_sram_responder_if.slave (req/wr/size/wstrb/addr/wdata in,
//           addr_ok/data_ok/rdata out)
// Configuration
//   DSRAM_RESP_STALL_EN  when defined, a free-running counter forces addr_ok
//                        low one cycle in every STALL_PERIOD to exercise
//                        requester stall handling. Undefined: no counter.
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int ADDR_W       = 10,
  parameter int LATENCY      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_PERIOD = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam int WORDS = 2 ** ADDR_W;

  logic [31:0]       ram_q      [WORDS];
  logic [31:0]       ent_data_q [FIFO_DEPTH];
  logic              ent_wr_q   [FIFO_DEPTH];
  // Age 0 marks an empty slot; a live entry counts 1..LATENCY.
  logic [AGE_W-1:0]  ent_age_q  [FIFO_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] idx;
  logic              stall;
  logic              push;
  logic              pop;

  // Low two bits select a byte within the word; bits above the index alias.
  assign idx = bus.addr[ADDR_W+1:2];

`ifdef DSRAM_RESP_STALL_EN
  localparam int STALL_W = $clog2(STALL_PERIOD);
  logic [STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q == STALL_W'(STALL_PERIOD - 1)) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + STALL_W'(1);
    end
  end

  assign stall = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1));

  logic unused_cfg;
  assign unused_cfg = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`else
  assign stall = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0],
                        STALL_PERIOD[0]};
`endif

  // Occupancy only: a pop this cycle does not open a slot for this cycle.
  assign bus.addr_ok = resetn & (count_q < CNT_W'(FIFO_DEPTH)) & ~stall;
  assign push        = bus.req & bus.addr_ok;
  // Only the head may complete, which keeps responses in request order.
  assign pop         = (ent_age_q[head_q] == AGE_W'(LATENCY));

  // NOTE: every output of this block gets a default before any branch so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    data_ok_d = pop;
    rdata_d   = '0;

    if (pop) begin
      head_d = head_q + PTR_W'(1);
      if (!ent_wr_q[head_q]) begin
        rdata_d = ent_data_q[head_q];
      end
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_age_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && (tail_q == PTR_W'(i))) begin
          ent_age_q[i] <= AGE_W'(1);
        end else if (pop && (head_q == PTR_W'(i))) begin
          ent_age_q[i] <= '0;
        end else if ((ent_age_q[i] != '0) && (ent_age_q[i] != AGE_W'(LATENCY))) begin
          ent_age_q[i] <= ent_age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // NOTE: RAM and entry payloads are deliberately not reset; validity lives
  // in the age counters, and leaving the array out of reset lets it map onto
  // a real SRAM macro.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_wr_q[tail_q] <= bus.wr;
      // Earlier stores are already committed, so this read sees them.
      ent_data_q[tail_q] <= ram_q[idx];
      if (bus.wr) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.wstrb[b]) begin
            ram_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//   Self-checking bench for data_sram_responder. Two instances share clock and
//   reset: dut_a (LATENCY 2, depth 4, full throughput) and dut_b (LATENCY 4,
//   depth 4, throughput limited by occupancy). A monitor keeps a word-level
//   memory model per instance, pushes the expected response and its due cycle
//   on every accept, and pops/compares on every data_ok.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  exp_t        sb  [2][$];
  logic [31:0] mdl [2][1024];

  data_sram_responder_if bus_a ();
  data_sram_responder_if bus_b ();

  data_sram_responder #(.LATENCY(LAT_A), .FIFO_DEPTH(4)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  data_sram_responder #(.LATENCY(LAT_B), .FIFO_DEPTH(4)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Runs at each negedge: inputs are stable, so req & addr_ok here is the
  // accept that the coming posedge performs.
  task automatic mon(input int id, input logic rq, input logic w, input logic [3:0] st,
                     input logic [31:0] ad, input logic [31:0] wd, input logic aok,
                     input logic dok, input logic [31:0] rd, input int lat);
    exp_t       e;
    logic [9:0] ix;
    if (dok) begin
      if (sb[id].size() == 0) begin
        check("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        e = sb[id].pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.due));
        check("rdata", rd, e.wr ? 32'h0 : e.data);
      end
    end
    if ((sb[id].size() > 0) && (sb[id][0].due <= cyc)) begin
      check("missing_data_ok", 32'd0, 32'd1);
      void'(sb[id].pop_front());
    end
    if (!resetn) begin
      sb[id].delete();
    end else if (rq && aok) begin
      ix = ad[11:2];
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) mdl[id][ix][8*b +: 8] = wd[8*b +: 8];
        end
      end
      e.wr   = w;
      e.data = mdl[id][ix];
      e.due  = cyc + 1 + lat;
      sb[id].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.req, bus_a.wr, bus_a.wstrb, bus_a.addr, bus_a.wdata,
        bus_a.addr_ok, bus_a.data_ok, bus_a.rdata, LAT_A);
    mon(1, bus_b.req, bus_b.wr, bus_b.wstrb, bus_b.addr, bus_b.wdata,
        bus_b.addr_ok, bus_b.data_ok, bus_b.rdata, LAT_B);
  end

  task automatic drive(input int id, input logic rq, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      bus_a.req = rq; bus_a.wr = w; bus_a.size = 2'd2;
      bus_a.wstrb = st; bus_a.addr = a; bus_a.wdata = d;
    end else begin
      bus_b.req = rq; bus_b.wr = w; bus_b.size = 2'd2;
      bus_b.wstrb = st; bus_b.addr = a; bus_b.wdata = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic aok_of(input int id);
    return (id == 0) ? bus_a.addr_ok : bus_b.addr_ok;
  endfunction

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input int id, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    drive(id, 1'b1, w, st, a, d);
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (aok_of(id)) got = 1'b1;
      else step();
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    step();
    drive(id, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (sb[0].size() != 0 || sb[1].size() != 0); t++) step();
    check("drain_a", 32'(sb[0].size()), 32'd0);
    check("drain_b", 32'(sb[1].size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    int   k;
    logic acc;

    // Reset held with req asserted: nothing may be accepted or returned.
    drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_addr_ok_a", 32'(bus_a.addr_ok), 32'd0);
      check("rst_addr_ok_b", 32'(bus_b.addr_ok), 32'd0);
      check("rst_data_ok_a", 32'(bus_a.data_ok), 32'd0);
      check("rst_data_ok_b", 32'(bus_b.data_ok), 32'd0);
      check("rst_rdata_a", bus_a.rdata, 32'h0);
      check("rst_rdata_b", bus_b.rdata, 32'h0);
    end
    step();
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;

    // Known contents for the words the later loads touch.
    for (int i = 0; i < 16; i++) issue(0, 1'b1, 4'hF, 32'(4 * i), $urandom);
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    drain();

    // Store then load of the same word on consecutive accepts.
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0);
    drain();

    // Single-lane store merges into the existing word.
    issue(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
    issue(0, 1'b1, 4'b0100, 32'h20, 32'h00AA_0000);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0);
    drain();

    // Mixed traffic: aliased upper bits, misaligned low bits, random strobes
    // (including zero), random idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      issue(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom & 32'hFFFF_F03F, $urandom);
    end
    drain();

    // LATENCY 4 with depth 4: req held 8 cycles, slot frees one cycle after pop.
    k = 0;
    drive(1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifndef DSRAM_RESP_STALL_EN
      check("full_addr_ok", 32'(bus_b.addr_ok), 32'(i != 4));
`endif
      acc = bus_b.addr_ok;
      step();
      if (acc) k++;
      drive(1, 1'b1, 1'b0, 4'h0, 32'h100 + 32'(4 * (k % 4)), 32'h0);
    end
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
`ifndef DSRAM_RESP_STALL_EN
    check("full_accepts", 32'(k), 32'd7);
`endif
    drain();

    // Reset one cycle before the first of three pending responses.
    issue(1, 1'b0, 4'h0, 32'h100, 32'h0);
    issue(1, 1'b0, 4'h0, 32'h104, 32'h0);
    issue(1, 1'b0, 4'h0, 32'h108, 32'h0);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_addr_ok", 32'(bus_b.addr_ok), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("post_rst_data_ok", 32'(bus_b.data_ok), 32'd0);
      @(negedge clk);
    end
    step();
    drain();

`ifdef DSRAM_RESP_STALL_EN
    // Stall counter restarts at reset; addr_ok drops on cycles 7 and 15.
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_addr_ok", 32'(bus_a.addr_ok), 32'((i % 8) != 7));
      step();
    end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
